// File: rtl/riscv_core_icache_pkg.sv
// Shared field widths, controller state encoding and address field helpers
// for the direct-mapped instruction cache.
package riscv_core_icache_pkg;

    localparam int ADDR_W         = 64;
    localparam int TAG_W          = 52;
    localparam int INDEX_W        = 7;
    localparam int BLOCK_OFFSET_W = 3;
    localparam int BYTE_OFFSET_W  = 2;
    localparam int BLOCK_LSB      = BLOCK_OFFSET_W + BYTE_OFFSET_W;
    localparam int BLOCK_NUM_W    = ADDR_W - BLOCK_LSB;

    typedef enum logic {
        COMPARE = 1'b0,
        REFILL  = 1'b1
    } icache_state_e;

    // Helpers take a block number (address >> BLOCK_LSB) so every bit is consumed.
    function automatic logic [TAG_W-1:0] f_tag(input logic [BLOCK_NUM_W-1:0] blk);
        return blk[BLOCK_NUM_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] f_index(input logic [BLOCK_NUM_W-1:0] blk);
        return blk[INDEX_W-1:0];
    endfunction

endpackage

// File: rtl/riscv_core_icache_tag_array.sv
// Tag and valid storage: two combinational lookup ports, one synchronous
// write port, single-cycle invalidate of every line.
module riscv_core_icache_tag_array
    import riscv_core_icache_pkg::*;
#(
    parameter int INDEX_WIDTH = INDEX_W,
    parameter int TAG_WIDTH   = TAG_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [INDEX_WIDTH-1:0] i_lo_idx,
    input  logic [INDEX_WIDTH-1:0] i_hi_idx,
    output logic [TAG_WIDTH-1:0]   o_lo_tag,
    output logic                   o_lo_valid,
    output logic [TAG_WIDTH-1:0]   o_hi_tag,
    output logic                   o_hi_valid,
    input  logic                   i_wr_en,
    input  logic [INDEX_WIDTH-1:0] i_wr_idx,
    input  logic [TAG_WIDTH-1:0]   i_wr_tag,
    input  logic                   i_flush
);

    localparam int SETS = 1 << INDEX_WIDTH;

    logic [TAG_WIDTH-1:0] r_tag [SETS];
    logic [SETS-1:0]      r_valid;

    // Tags carry no reset; the valid bits alone decide whether a tag is meaningful.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
    end

    // Flush wins over a same-cycle write so a refill racing a fence.i stays invalid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    assign o_lo_tag   = r_tag[i_lo_idx];
    assign o_lo_valid = r_valid[i_lo_idx];
    assign o_hi_tag   = r_tag[i_hi_idx];
    assign o_hi_valid = r_valid[i_hi_idx];

endmodule

// File: rtl/riscv_core_icache_controller.sv
// Hit/miss sequencing for the instruction cache: serves hits combinationally,
// refills missing lines (lo before hi for block-straddling fetches), handles fence.i.
module riscv_core_icache_controller
    import riscv_core_icache_pkg::*;
#(
    parameter int INDEX_WIDTH        = INDEX_W,
    parameter int BLOCK_OFFSET_WIDTH = BLOCK_OFFSET_W,
    parameter int TAG_WIDTH          = TAG_W,
    parameter int ADDR_WIDTH         = ADDR_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_flush,
    output logic                  o_stall,
    output logic                  o_rd_en,
    output logic                  o_wr_en,
    output logic                  o_block_replace,
    output logic                  o_offset,
    output logic                  o_axi_req,
    output logic [ADDR_WIDTH-1:0] o_axi_addr,
    input  logic                  i_axi_valid,
    output logic [31:0]           o_miss_count
);

    localparam int BLK_LSB = BLOCK_OFFSET_WIDTH + BYTE_OFFSET_W;
    localparam int BLK_W   = ADDR_WIDTH - BLK_LSB;

    icache_state_e r_state;
    icache_state_e w_state_next;

    logic                  r_target;
    logic                  r_flush_pending;
    logic [ADDR_WIDTH-1:0] r_axi_addr;
    logic [31:0]           r_miss_count;

    logic [BLK_W-1:0]       w_lo_blk;
    logic [BLK_W-1:0]       w_hi_blk;
    logic                   w_needs_hi;
    logic [TAG_WIDTH-1:0]   w_lo_tag;
    logic [TAG_WIDTH-1:0]   w_hi_tag;
    logic                   w_lo_valid;
    logic                   w_hi_valid;
    logic                   w_lo_hit;
    logic                   w_hi_hit;
    logic                   w_hit;
    logic                   w_miss_start;
    logic                   w_refill_done;
    logic                   w_tag_flush;
    logic                   w_unused_addr_lsb;

    // Fetches are halfword aligned, so the byte bit never matters.
    assign w_unused_addr_lsb = i_addr[0];

    // i_addr+2 leaves the block only when addr[4:1] is all ones, in which case
    // its block number is simply the next one (wrapping past the top of memory).
    assign w_lo_blk   = i_addr[ADDR_WIDTH-1:BLK_LSB];
    assign w_hi_blk   = w_lo_blk + 1'b1;
    assign w_needs_hi = &i_addr[BLK_LSB-1:1];

    riscv_core_icache_tag_array #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH)
    ) u_tag_array (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_lo_idx   (f_index(w_lo_blk)),
        .i_hi_idx   (f_index(w_hi_blk)),
        .o_lo_tag   (w_lo_tag),
        .o_lo_valid (w_lo_valid),
        .o_hi_tag   (w_hi_tag),
        .o_hi_valid (w_hi_valid),
        .i_wr_en    (w_refill_done),
        .i_wr_idx   (f_index(r_axi_addr[ADDR_WIDTH-1:BLK_LSB])),
        .i_wr_tag   (f_tag(r_axi_addr[ADDR_WIDTH-1:BLK_LSB])),
        .i_flush    (w_tag_flush)
    );

    assign w_lo_hit      = w_lo_valid && (w_lo_tag == f_tag(w_lo_blk));
    assign w_hi_hit      = w_hi_valid && (w_hi_tag == f_tag(w_hi_blk));
    assign w_hit         = w_lo_hit && (!w_needs_hi || w_hi_hit);
    assign w_miss_start  = (r_state == COMPARE) && i_req && !w_hit;
    assign w_refill_done = (r_state == REFILL) && i_axi_valid;
    assign w_tag_flush   = ((r_state == COMPARE) && i_flush) ||
                           (w_refill_done && (r_flush_pending || i_flush));

    always_comb begin
        w_state_next    = r_state;
        o_stall         = 1'b0;
        o_rd_en         = 1'b0;
        o_wr_en         = 1'b0;
        o_block_replace = 1'b0;
        o_offset        = 1'b0;
        o_axi_req       = 1'b0;
        case (r_state)
            COMPARE: begin
                if (i_req) begin
                    if (w_hit) begin
                        o_rd_en = 1'b1;
                    end else begin
                        o_stall      = 1'b1;
                        w_state_next = REFILL;
                    end
                end
            end
            REFILL: begin
                o_stall   = 1'b1;
                o_axi_req = 1'b1;
                if (i_axi_valid) begin
                    o_wr_en         = 1'b1;
                    o_block_replace = 1'b1;
                    o_offset        = r_target;
                    w_state_next    = COMPARE;
                end
            end
            default: w_state_next = COMPARE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= COMPARE;
            r_target        <= 1'b0;
            r_flush_pending <= 1'b0;
            r_axi_addr      <= '0;
            r_miss_count    <= '0;
        end else begin
            r_state <= w_state_next;
            // Lo line is refilled first; only when it already hits do we go for hi.
            if (w_miss_start) begin
                r_target   <= w_lo_hit;
                r_axi_addr <= {(w_lo_hit ? w_hi_blk : w_lo_blk), {BLK_LSB{1'b0}}};
            end
            if (w_refill_done) begin
                r_miss_count    <= r_miss_count + 32'd1;
                r_flush_pending <= 1'b0;
            end else if ((r_state == REFILL) && i_flush) begin
                r_flush_pending <= 1'b1;
            end
        end
    end

    assign o_axi_addr   = r_axi_addr;
    assign o_miss_count = r_miss_count;

endmodule

// File: tb/tb_riscv_core_icache_controller.sv
// Scoreboard bench for the instruction cache controller: directed fetches push
// expected refill/write/hit events; a negedge monitor pops and compares them.
module tb_riscv_core_icache_controller;

    localparam int EV_REQ = 0;
    localparam int EV_WR  = 1;
    localparam int EV_HIT = 2;

    typedef struct {
        int          kind;
        logic [63:0] val;
    } evt_t;

    logic        clk;
    logic        i_rst_n;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_flush;
    logic        o_stall;
    logic        o_rd_en;
    logic        o_wr_en;
    logic        o_block_replace;
    logic        o_offset;
    logic        o_axi_req;
    logic [63:0] o_axi_addr;
    logic        i_axi_valid;
    logic [31:0] o_miss_count;

    evt_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        prev_req = 1'b0;
    logic [63:0] prev_addr = '0;

    riscv_core_icache_controller dut (
        .i_clk           (clk),
        .i_rst_n         (i_rst_n),
        .i_req           (i_req),
        .i_addr          (i_addr),
        .i_flush         (i_flush),
        .o_stall         (o_stall),
        .o_rd_en         (o_rd_en),
        .o_wr_en         (o_wr_en),
        .o_block_replace (o_block_replace),
        .o_offset        (o_offset),
        .o_axi_req       (o_axi_req),
        .o_axi_addr      (o_axi_addr),
        .i_axi_valid     (i_axi_valid),
        .o_miss_count    (o_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_evt(input int k, input logic [63:0] v);
        q.push_back('{kind: k, val: v});
    endtask

    task automatic see_evt(input int k, input logic [63:0] v, input string nm);
        evt_t e;
        n_checks++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event kind %0d value 0x%0h, nothing expected", nm, k, v);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.val !== v) begin
                n_fail++;
                $display("FAIL %s: got kind %0d value 0x%0h, expected kind %0d value 0x%0h",
                         nm, k, v, e.kind, e.val);
            end
        end
    endtask

    // Monitor: refill start, block write (value = {block_replace, offset}), hit.
    always @(negedge clk) begin
        if (i_rst_n) begin
            if (o_axi_req && !prev_req) see_evt(EV_REQ, o_axi_addr, "axi_req");
            if (o_axi_req && prev_req)  chk("axi_addr_stable", o_axi_addr, prev_addr);
            if (o_wr_en) see_evt(EV_WR, {62'd0, o_block_replace, o_offset}, "block_write");
            if (o_rd_en) see_evt(EV_HIT, i_addr, "hit");
        end
        prev_req  = o_axi_req;
        prev_addr = o_axi_addr;
    end

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_req = 1'b0; i_flush = 1'b0; i_axi_valid = 1'b0; i_addr = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_rst_n = 1'b1;
    endtask

    // Holds the fetch until served; answers each refill request after lat cycles.
    task automatic do_fetch(input logic [63:0] a, input int lat);
        int w = 0;
        i_req = 1'b1;
        i_addr = a;
        for (int g = 0; g < 100; g++) begin
            #2;
            if (!o_stall) begin
                @(posedge clk); #1;
                i_req = 1'b0;
                return;
            end
            if (o_axi_req) begin
                if (w == lat) begin
                    i_axi_valid = 1'b1;
                    w = 0;
                end else begin
                    w++;
                end
            end
            @(posedge clk); #1;
            i_axi_valid = 1'b0;
        end
        n_checks++;
        n_fail++;
        $display("FAIL fetch_timeout: addr 0x%0h still stalled after 100 cycles, expected service", a);
        i_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0;
        i_req = 1'b0; i_flush = 1'b0; i_axi_valid = 1'b0; i_addr = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_stall", {63'd0, o_stall}, 64'd0);
        chk("rst_rd_en", {63'd0, o_rd_en}, 64'd0);
        chk("rst_wr_en", {63'd0, o_wr_en}, 64'd0);
        chk("rst_block_replace", {63'd0, o_block_replace}, 64'd0);
        chk("rst_offset", {63'd0, o_offset}, 64'd0);
        chk("rst_axi_req", {63'd0, o_axi_req}, 64'd0);
        chk("rst_axi_addr", o_axi_addr, 64'd0);
        chk("rst_miss_count", {32'd0, o_miss_count}, 64'd0);
        i_rst_n = 1'b1;

        // Cold fetch, refill returned 3 cycles after the request, then a hit.
        push_evt(EV_REQ, 64'h1000); push_evt(EV_WR, 64'd2); push_evt(EV_HIT, 64'h1000);
        do_fetch(64'h1000, 3);
        chk("cold_miss_count", {32'd0, o_miss_count}, 64'd1);
        push_evt(EV_HIT, 64'h1004);
        do_fetch(64'h1004, 0);
        chk("hit_miss_count", {32'd0, o_miss_count}, 64'd1);

        // Straddling fetch with both blocks cold: lo refill then hi refill.
        do_reset();
        push_evt(EV_REQ, 64'h1000); push_evt(EV_WR, 64'd2);
        push_evt(EV_REQ, 64'h1020); push_evt(EV_WR, 64'd3);
        push_evt(EV_HIT, 64'h101E);
        do_fetch(64'h101E, 1);
        chk("straddle_miss_count", {32'd0, o_miss_count}, 64'd2);

        // Conflict on index 0.
        do_reset();
        push_evt(EV_REQ, 64'h1000); push_evt(EV_WR, 64'd2); push_evt(EV_HIT, 64'h1000);
        do_fetch(64'h1000, 1);
        push_evt(EV_REQ, 64'h2000); push_evt(EV_WR, 64'd2); push_evt(EV_HIT, 64'h2000);
        do_fetch(64'h2000, 0);
        push_evt(EV_REQ, 64'h1000); push_evt(EV_WR, 64'd2); push_evt(EV_HIT, 64'h1000);
        do_fetch(64'h1000, 2);
        chk("conflict_miss_count", {32'd0, o_miss_count}, 64'd3);

        // Flush in COMPARE: resident line must miss again.
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        push_evt(EV_REQ, 64'h1000); push_evt(EV_WR, 64'd2); push_evt(EV_HIT, 64'h1000);
        do_fetch(64'h1000, 0);
        chk("flush_miss_count", {32'd0, o_miss_count}, 64'd4);

        // Flush during REFILL: write happens but no line is left valid.
        push_evt(EV_REQ, 64'h1040); push_evt(EV_WR, 64'd2);
        i_req = 1'b1; i_addr = 64'h1040;
        @(posedge clk); #1;
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0; i_axi_valid = 1'b1; i_req = 1'b0;
        @(posedge clk); #1;
        i_axi_valid = 1'b0;
        chk("flush_refill_count", {32'd0, o_miss_count}, 64'd5);
        push_evt(EV_REQ, 64'h1040); push_evt(EV_WR, 64'd2); push_evt(EV_HIT, 64'h1040);
        do_fetch(64'h1040, 0);
        push_evt(EV_REQ, 64'h1000); push_evt(EV_WR, 64'd2); push_evt(EV_HIT, 64'h1000);
        do_fetch(64'h1000, 0);
        chk("after_flush_count", {32'd0, o_miss_count}, 64'd7);

        // Reset asserted mid-refill.
        push_evt(EV_REQ, 64'h3000);
        i_req = 1'b1; i_addr = 64'h3000;
        @(posedge clk); #1;
        #2 chk("midrefill_axi_req", {63'd0, o_axi_req}, 64'd1);
        @(negedge clk); #1;
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_axi_req", {63'd0, o_axi_req}, 64'd0);
        chk("async_rst_count", {32'd0, o_miss_count}, 64'd0);
        i_req = 1'b0;
        @(posedge clk); #1;
        i_rst_n = 1'b1;
        @(posedge clk); #1;
        i_axi_valid = 1'b1;
        #2 chk("stray_valid_wr_en", {63'd0, o_wr_en}, 64'd0);
        @(posedge clk); #1;
        i_axi_valid = 1'b0;
        chk("stray_valid_count", {32'd0, o_miss_count}, 64'd0);
        push_evt(EV_REQ, 64'h1040); push_evt(EV_WR, 64'd2); push_evt(EV_HIT, 64'h1040);
        do_fetch(64'h1040, 0);

        // Address wrap: hi line of the top halfword is block 0.
        do_reset();
        push_evt(EV_REQ, 64'hFFFF_FFFF_FFFF_FFE0); push_evt(EV_WR, 64'd2);
        push_evt(EV_REQ, 64'h0); push_evt(EV_WR, 64'd3);
        push_evt(EV_HIT, 64'hFFFF_FFFF_FFFF_FFFE);
        do_fetch(64'hFFFF_FFFF_FFFF_FFFE, 2);
        chk("wrap_miss_count", {32'd0, o_miss_count}, 64'd2);

        @(posedge clk); #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_core_icache_controller.md
# riscv_core_icache_controller

Sequencing controller for the direct-mapped instruction cache data array (128 sets × 32-byte blocks, 64-bit address). It owns the tag and valid storage and decides hit or miss for every fetch. On a miss it issues block refills to the AXI read module and drives the data array's read, write, block-replace and offset strobes. It also handles 32-bit fetches at halfword alignment that straddle two blocks (compressed ISA), cache flush (`fence.i`) and a miss counter.

## Interface
- `INDEX_WIDTH`, 7, set index bits (`addr[11:5]`).
- `BLOCK_OFFSET_WIDTH`, 3, word-in-block bits (`addr[4:2]`).
- `TAG_WIDTH`, 52, tag bits (`addr[63:12]`).
- `ADDR_WIDTH`, 64, fetch address width.
- `i_clk` in 1: single clock; all state updates on its rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_req` in 1: core fetch request valid.
- `i_addr` in ADDR_WIDTH: fetch address, halfword aligned. The core holds it stable while `o_stall`=1.
- `i_flush` in 1: invalidate all lines (`fence.i`), single-cycle pulse.
- `o_stall` in 1 out: fetch not serviceable this cycle.
- `o_rd_en` out 1: data array read enable; asserted exactly when a hit is being served.
- `o_wr_en`, `o_block_replace` out 1 each: data array block write.
- `o_offset` out 1: 0 = write the block of `i_addr`; 1 = write the block of `i_addr+2`.
- `o_axi_req` out 1: refill request.
- `o_axi_addr` out ADDR_WIDTH: block-aligned refill address (`[4:0]`=0).
- `i_axi_valid` in 1: refill block present on the data array's block input this cycle.
- `o_miss_count` out 32: count of refills completed; wraps modulo 2^32.

## Operation
- The lo line is the block of `i_addr`.
- The hi line is the block of `i_addr+2`, computed modulo 2^64. The hi line is needed only when `i_addr[4:1]==4'hF`.
- `lo_hit` = valid[idx] && tag[idx]==`i_addr[63:12]`. `hi_hit` is the same test using `i_addr+2`.
- The fetch hits when `lo_hit` && (!needs_hi || `hi_hit`). When needs_hi is set and both addresses map to the same index, both lines must still match.
- State COMPARE (reset state):
  - If `i_req`=0: all strobes low, `o_stall`=0.
  - If `i_req`=1 and the fetch hits: `o_rd_en`=1, `o_stall`=0, stay in COMPARE.
  - If `i_req`=1 and the fetch misses: `o_stall`=1. Latch target = lo if !`lo_hit`, else hi. Go to REFILL.
- State REFILL:
  - `o_stall`=1, `o_axi_req`=1, and `o_axi_addr` = target block address, all held constant.
  - When `i_axi_valid`=1: `o_wr_en`=`o_block_replace`=1 and `o_offset`=target.
  - On the same edge, write the tag and set the valid bit for the target index, increment `o_miss_count`, and return to COMPARE.
  - COMPARE then re-evaluates, so a straddling fetch with both lines missing takes two refills, lo first.
- Flush:
  - In COMPARE, `i_flush` clears all valid bits on that edge. A hit evaluated in the same cycle is still served using the pre-flush state.
  - In REFILL, `i_flush` is latched as pending. The refill still completes its write, but its valid bit is not set. All valid bits clear on the completion edge, then the pending flag clears.
- Reset mid-refill: the state returns to COMPARE, all valid bits clear, the counter clears and `o_axi_req` drops immediately. A later `i_axi_valid` in COMPARE is ignored (no write).
- `i_axi_valid` in COMPARE is always ignored.

## Timing
- Reset values:
  - Outputs `o_stall`, `o_rd_en`, `o_wr_en`, `o_block_replace`, `o_offset`, `o_axi_req`, `o_axi_addr` = 0.
  - `o_miss_count`=0.
  - All valid bits 0.
- Hit: zero added latency. `o_rd_en` and `!o_stall` are combinational in the request cycle, and the data array read is combinational.
- Miss:
  - Cycle 0: COMPARE with `o_stall`=1.
  - Cycle 1 onward: `o_axi_req`=1 until `i_axi_valid`.
  - The write happens on the `i_axi_valid` cycle.
  - The next cycle is COMPARE, where a hit is served.
  - Single-miss service = 2 + N cycles, where N is the number of cycles from request to `i_axi_valid` (N≥0 counted from cycle 1).
- `o_axi_addr` is registered and must not change while `o_axi_req`=1.

## Structure
- Package `riscv_core_icache_pkg`:
  - Field width localparams (TAG, INDEX, BLOCK_OFFSET, BYTE_OFFSET).
  - State enum `icache_state_e` {COMPARE, REFILL}.
  - Field-extract functions. These replace the per-file `define`s.
- Sub-module `riscv_core_icache_tag_array`:
  - 128×(52-bit tag + valid).
  - Two combinational read ports (lo and hi).
  - One synchronous write port.
  - Single-cycle flush of all valid bits.
  - Asynchronous clear.

## Test plan
- Cold fetch at 0x1000:
  - Expect `o_axi_addr`=0x1000.
  - Return a block 3 cycles later: one write with `o_offset`=0, `o_miss_count`=1.
  - The next fetch of 0x1004 hits with no stall.
- Straddle fetch at 0x101E, both blocks cold:
  - Expect a refill of 0x1000 (`o_offset`=0), then a refill of 0x1020 (`o_offset`=1).
  - Then `o_rd_en`=1; `o_miss_count`=2.
- Conflict: fill 0x1000, then fetch 0x2000 (same index 0, different tag).
  - Expect a miss and a refill of 0x2000.
  - A refetch of 0x1000 then misses again.
- Flush:
  - After filling 0x1000, pulse `i_flush`; the next fetch of 0x1000 misses.
  - Assert `i_flush` during REFILL: the refilled line is not valid afterward.
- Reset asserted mid-REFILL:
  - `o_axi_req` drops asynchronously and the counter reads 0.
  - A stray `i_axi_valid` after reset produces no `o_wr_en`.
- Address wrap: fetch at 0xFFFF_FFFF_FFFF_FFFE needs the hi line at 0x0. Expect refills of 0xFFFF_FFFF_FFFF_FFE0, then 0x0.
